instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Upstream neighbour of the multi-cycle control FSM.
- Owns the program counter and fetches instructions over a req/ack instruction-memory port.
- Holds the instruction register and presents decoded fields (op_code, rs, rt, rd, imm) to the control FSM and datapath.
- On the control FSM's loadPC pulse, resolves the next PC from the BRANCH select and the ALU flags.

Parameters:
- ADDR_W, 16: PC and instruction-address width (word-addressed).
- INSTR_W, 32: instruction width.
- RESET_PC, 0: PC value loaded on reset.
- TIMEOUT_CYCLES, 255: fetch watchdog limit. Used only with FETCH_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  fetch address (= pc).
- imem_ack  in  1  one-cycle pulse: imem_rdata is valid this cycle.
- imem_rdata  in  INSTR_W  fetched instruction.
- loadPC  in  1  from control FSM: commit the next PC this cycle.
- BRANCH  in  3  branch select: 000 none, 001 BR, 010 BMI, 011 BPL, 100 BZ, 101 JR.
- flag_n  in  1  ALU negative flag.
- flag_z  in  1  ALU zero flag.
- jr_target  in  ADDR_W  register-sourced jump target.
- pc  out  ADDR_W  address of the instruction held in instr.
- instr  out  INSTR_W  instruction register.
- op_code  out  4  instr[31:28].
- rs  out  4  instr[27:24].
- rt  out  4  instr[23:20].
- rd  out  4  instr[19:16].
- imm  out  16  instr[15:0].
- instr_valid  out  1  instr holds a completed fetch.
- fetch_err  out  1  sticky watchdog error.

Behaviour:
- Reset values (reset low, asynchronous):
  - state = IDLE, pc = RESET_PC.
  - instr = 32'hE000_0000 (NOP opcode).
  - imem_req = 0, instr_valid = 0, fetch_err = 0.
- States: IDLE, REQ, HOLD, ERR.
- IDLE: one cycle, then REQ. imem_ack is ignored here, which discards responses to requests abandoned by a mid-fetch reset.
- REQ:
  - imem_req = 1 and imem_addr = pc, both held stable until ack.
  - On imem_ack: instr <= imem_rdata, instr_valid <= 1 on the next edge, go to HOLD.
  - Fetch latency is 1 cycle after ack. Minimum fetch is 2 cycles when ack arrives in the first REQ cycle.
- HOLD:
  - instr_valid = 1 and instr stable. The block waits indefinitely, which is how HALT stalls.
  - On loadPC: pc <= next_pc, instr_valid <= 0, go to REQ.
  - loadPC in REQ, IDLE or ERR is ignored.
- next_pc, computed combinationally in the loadPC cycle from flags sampled that cycle:
  - seq = pc + 1.
  - tgt = pc + 1 + sign-extended imm, truncated to ADDR_W.
  - 000 -> seq.
  - 001 -> tgt.
  - 010 -> tgt if flag_n, else seq.
  - 011 -> tgt if !flag_n && !flag_z, else seq.
  - 100 -> tgt if flag_z, else seq.
  - 101 -> jr_target.
  - 110, 111 -> seq.
- Arithmetic is modulo 2^ADDR_W: pc = all-ones wraps to 0.
- imem_ack arriving together with a state change is only honoured in REQ.
- Decoded field outputs are pure slices of instr, with no extra latency.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- When defined:
  - An 8+ bit counter clears on entry to REQ and increments each REQ cycle without ack.
  - When it reaches TIMEOUT_CYCLES: imem_req drops, fetch_err <= 1, instr_valid stays 0, state -> ERR.
  - ERR is terminal until reset.
  - An ack in the same cycle as expiry wins: normal capture, no error.
- When undefined: REQ waits forever, fetch_err is tied 0, and ERR is unreachable.

Decomposition:
- Shared package (cpu_pkg) holds:
  - Opcode constants (ALU = 4'h0 … JR = 4'hA, NOP = 4'hE, HALT = 4'hF).
  - BRANCH encodings.
  - Instruction field bit positions.
  - Fetch state encoding.
- One natural sub-module: branch_resolver, purely combinational. Inputs: pc, imm, BRANCH, flag_n, flag_z, jr_target. Output: next_pc. The control FSM's branch testing can reuse it.

Test Plan:
- Reset release, memory returning 32'h1123_0005 with 3-cycle ack latency -> imem_addr = 0 during REQ; instr_valid rises 1 cycle after ack; op_code = 1, rs = 1, rt = 2, rd = 3, imm = 5.
- pc = 10, BRANCH = 001, imm = 16'hFFFC, loadPC -> next imem_addr = 7. Repeat with BRANCH = 100: flag_z = 0 gives 11, flag_z = 1 gives 7.
- BRANCH = 011 with (flag_n, flag_z) = (0,0), (1,0), (0,1) from pc = 20, imm = 4 -> next PC 25, 21, 21 respectively. BRANCH = 101, jr_target = 16'h0040 -> next PC 0x0040.
- Hold in HOLD for 50 cycles without loadPC (HALT) -> instr and pc unchanged, no imem_req. pc = 16'hFFFF with BRANCH = 000 -> next PC 0.
- Assert reset mid-REQ, then pulse imem_ack during IDLE -> ack ignored, instr = NOP, fetch restarts at RESET_PC.
- With FETCH_TIMEOUT_EN and TIMEOUT_CYCLES = 8, never ack -> fetch_err = 1 after 8 REQ cycles, imem_req = 0, stays in ERR until reset. Ack exactly on cycle 8 -> normal capture, fetch_err = 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, BRANCH select encodings, instruction field
// positions and the fetch-unit state encoding.
package cpu_pkg;

    localparam logic [3:0] OP_ALU  = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_LDI  = 4'h4;
    localparam logic [3:0] OP_BR   = 4'h5;
    localparam logic [3:0] OP_BMI  = 4'h6;
    localparam logic [3:0] OP_BPL  = 4'h7;
    localparam logic [3:0] OP_BZ   = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_JR   = 4'hA;
    localparam logic [3:0] OP_NOP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_BR   = 3'b001;
    localparam logic [2:0] BR_BMI  = 3'b010;
    localparam logic [2:0] BR_BPL  = 3'b011;
    localparam logic [2:0] BR_BZ   = 3'b100;
    localparam logic [2:0] BR_JR   = 3'b101;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 28;
    localparam int RS_MSB  = 27;
    localparam int RS_LSB  = 24;
    localparam int RT_MSB  = 23;
    localparam int RT_LSB  = 20;
    localparam int RD_MSB  = 19;
    localparam int RD_LSB  = 16;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    localparam logic [31:0] NOP_INSTR = {OP_NOP, 28'h0};

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
        FS_HOLD = 2'd2,
        FS_ERR  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/branch_resolver.sv
// Combinational next-PC selection from the BRANCH select, the ALU flags and
// the PC-relative immediate; all arithmetic wraps modulo 2^ADDR_W.
module branch_resolver
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [15:0]       imm,
    input  logic [2:0]        branch_sel,
    input  logic              flag_n,
    input  logic              flag_z,
    input  logic [ADDR_W-1:0] jr_target,
    output logic [ADDR_W-1:0] next_pc
);

    logic [ADDR_W-1:0] imm_ext;
    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] tgt_pc;

    always_comb begin
        imm_ext = ADDR_W'($signed(imm));
        seq_pc  = pc + ADDR_W'(1);
        tgt_pc  = seq_pc + imm_ext;
        next_pc = seq_pc;
        case (branch_sel)
            BR_BR:   next_pc = tgt_pc;
            BR_BMI:  if (flag_n) next_pc = tgt_pc;
            BR_BPL:  if (!flag_n && !flag_z) next_pc = tgt_pc;
            BR_BZ:   if (flag_z) next_pc = tgt_pc;
            BR_JR:   next_pc = jr_target;
            default: next_pc = seq_pc;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC and instruction register, fetches over a
// req/ack port. Optional fetch watchdog enabled by FETCH_TIMEOUT_EN.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W         = 16,
    parameter int                INSTR_W        = 32,
    parameter logic [ADDR_W-1:0] RESET_PC       = '0,
    parameter int                TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               loadPC,
    input  logic [2:0]         BRANCH,
    input  logic               flag_n,
    input  logic               flag_z,
    input  logic [ADDR_W-1:0]  jr_target,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         op_code,
    output logic [3:0]         rs,
    output logic [3:0]         rt,
    output logic [3:0]         rd,
    output logic [15:0]        imm,
    output logic               instr_valid,
    output logic               fetch_err,
    output logic [1:0]         fetch_state
);

    // Handshake: imem_req is high for every REQ cycle with imem_addr held at
    // pc; imem_ack is a one-cycle pulse whose data is captured on that edge.
    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    logic [ADDR_W-1:0]  next_pc;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             timeout_hit;

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic timeout_unused;
    assign timeout_unused = ^TIMEOUT_CYCLES;
`endif

    branch_resolver #(.ADDR_W(ADDR_W)) u_branch_resolver (
        .pc         (pc_q),
        .imm        (instr_q[IMM_MSB:IMM_LSB]),
        .branch_sel (BRANCH),
        .flag_n     (flag_n),
        .flag_z     (flag_z),
        .jr_target  (jr_target),
        .next_pc    (next_pc)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
`ifdef FETCH_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            // IDLE drops any ack belonging to a fetch abandoned by reset.
            FS_IDLE: begin
                state_d = FS_REQ;
`ifdef FETCH_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            FS_REQ: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    state_d = FS_HOLD;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = FS_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            FS_HOLD: begin
                if (loadPC) begin
                    pc_d    = next_pc;
                    valid_d = 1'b0;
                    state_d = FS_REQ;
`ifdef FETCH_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            FS_ERR:  state_d = FS_ERR;
            default: state_d = FS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FS_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= INSTR_W'(NOP_INSTR);
            valid_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
`ifdef FETCH_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign imem_req    = (state_q == FS_REQ);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign op_code     = instr_q[OP_MSB:OP_LSB];
    assign rs          = instr_q[RS_MSB:RS_LSB];
    assign rt          = instr_q[RT_MSB:RT_LSB];
    assign rd          = instr_q[RD_MSB:RD_LSB];
    assign imm         = instr_q[IMM_MSB:IMM_LSB];
    assign instr_valid = valid_q;
    assign fetch_state = state_q;
`ifdef FETCH_TIMEOUT_EN
    assign fetch_err   = err_q;
`else
    assign fetch_err   = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: transaction-level model plus
// directed branch/reset/halt vectors (watchdog vectors with FETCH_TIMEOUT_EN).
module tb_instr_fetch_unit;

    localparam int ADDR_W = 16;
    localparam int INSTR_W = 32;
    localparam int TO = 8;
`ifdef FETCH_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               loadPC;
    logic [2:0]         BRANCH;
    logic               flag_n;
    logic               flag_z;
    logic [ADDR_W-1:0]  jr_target;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
    logic [3:0]         op_code, rs, rt, rd;
    logic [15:0]        imm;
    logic               instr_valid;
    logic               fetch_err;
    logic [1:0]         fetch_state;

    int n_checks = 0;
    int n_errors = 0;

    // Model: fetch bookkeeping tracked as transactions, not as a state register.
    logic [15:0] m_pc;
    logic [31:0] m_instr;
    bit          m_valid, m_req, m_err, m_idle;
    int          m_wait;

    instr_fetch_unit #(
        .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(16'h0000), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .loadPC(loadPC), .BRANCH(BRANCH),
        .flag_n(flag_n), .flag_z(flag_z), .jr_target(jr_target), .pc(pc), .instr(instr),
        .op_code(op_code), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
        .instr_valid(instr_valid), .fetch_err(fetch_err), .fetch_state(fetch_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_next(input logic [15:0] cur, input logic [15:0] off,
                                             input logic [2:0] br, input logic n, input logic z,
                                             input logic [15:0] jr);
        logic [15:0] seq_v, tgt_v;
        bit take;
        seq_v = 16'(int'(cur) + 1);
        tgt_v = 16'(int'(cur) + 1 + int'($signed(off)));
        case (br)
            3'd1:    take = 1'b1;
            3'd2:    take = n;
            3'd3:    take = !n && !z;
            3'd4:    take = z;
            default: take = 1'b0;
        endcase
        if (br == 3'd5) return jr;
        return take ? tgt_v : seq_v;
    endfunction

    // Model update on each rising edge, then compare once outputs settle.
    initial begin
        forever begin
            @(posedge clk);
            if (!reset) begin
                m_pc = 16'h0000; m_instr = 32'hE000_0000;
                m_valid = 0; m_req = 0; m_err = 0; m_idle = 1; m_wait = 0;
            end else if (m_err) begin
                m_err = 1;
            end else if (m_idle) begin
                m_idle = 0; m_req = 1; m_wait = 0;
            end else if (m_req) begin
                if (imem_ack) begin
                    m_instr = imem_rdata; m_valid = 1; m_req = 0;
                end else if (TO_EN && (m_wait + 1 == TO)) begin
                    m_req = 0; m_err = 1;
                end else begin
                    m_wait++;
                end
            end else if (m_valid && loadPC) begin
                m_pc = ref_next(m_pc, m_instr[15:0], BRANCH, flag_n, flag_z, jr_target);
                m_valid = 0; m_req = 1; m_wait = 0;
            end
            #1;
            check("cyc_req", imem_req, m_req);
            check("cyc_pc", pc, m_pc);
            check("cyc_instr", instr, m_instr);
            check("cyc_valid", instr_valid, m_valid);
            check("cyc_err", fetch_err, m_err);
            check("cyc_fields", {op_code, rs, rt, rd, imm}, m_instr);
            if (m_req) check("cyc_addr", imem_addr, m_pc);
        end
    end

    task automatic serve(input int lat, input logic [31:0] d, input logic [15:0] exp_addr,
                         input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (imem_req) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_checks++; n_errors++;
            $display("FAIL %s: imem_req never rose within 100 cycles", name);
            return;
        end
        check({name, "_addr"}, imem_addr, exp_addr);
        repeat (lat - 1) @(negedge clk);
        imem_ack = 1'b1; imem_rdata = d;
        @(negedge clk);
        imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
        check({name, "_valid"}, instr_valid, 1);
    endtask

    task automatic load_pc(input logic [2:0] br, input logic n, input logic z,
                           input logic [15:0] jr);
        bit ok;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (instr_valid) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_checks++; n_errors++;
            $display("FAIL load_pc: instr_valid never rose within 100 cycles");
            return;
        end
        loadPC = 1'b1; BRANCH = br; flag_n = n; flag_z = z; jr_target = jr;
        @(negedge clk);
        loadPC = 1'b0; BRANCH = 3'b000; flag_n = 1'b0; flag_z = 1'b0;
        jr_target = 16'($urandom_range(0, 65535));
    endtask

    logic [1:0]  bpl_nz [3] = '{2'b00, 2'b10, 2'b01};
    logic [15:0] bpl_exp[3] = '{16'd25, 16'd21, 16'd21};

    initial begin
        reset = 1'b0; imem_ack = 1'b0; imem_rdata = '0; loadPC = 1'b0;
        BRANCH = 3'b000; flag_n = 1'b0; flag_z = 1'b0; jr_target = '0;
        repeat (3) @(negedge clk);
        check("rst_instr", instr, 32'hE000_0000);
        check("rst_pc", pc, 16'h0000);
        check("rst_req", imem_req, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_err", fetch_err, 0);
        reset = 1'b1;

        serve(3, 32'h1123_0005, 16'h0000, "fetch0");
        check("f0_op", op_code, 4'h1);
        check("f0_rs", rs, 4'h1);
        check("f0_rt", rt, 4'h2);
        check("f0_rd", rd, 4'h3);
        check("f0_imm", imm, 16'h0005);

        load_pc(3'b101, 0, 0, 16'd10); serve(1, 32'h5000_FFFC, 16'd10, "to10a");
        load_pc(3'b001, 0, 0, 16'd0);  serve(1, 32'h8000_FFFC, 16'd7, "br_back");
        load_pc(3'b101, 0, 0, 16'd10); serve(1, 32'h8000_FFFC, 16'd10, "to10b");
        load_pc(3'b100, 0, 0, 16'd0);  serve(1, 32'h7000_0004, 16'd11, "bz_nt");
        load_pc(3'b101, 0, 0, 16'd10); serve(1, 32'h8000_FFFC, 16'd10, "to10c");
        load_pc(3'b100, 0, 1, 16'd0);  serve(2, 32'h7000_0004, 16'd7, "bz_t");

        for (int k = 0; k < 3; k++) begin
            load_pc(3'b101, 0, 0, 16'd20); serve(2, 32'h7000_0004, 16'd20, "to20");
            load_pc(3'b011, bpl_nz[k][1], bpl_nz[k][0], 16'd0);
            serve(1, 32'h0000_0000, bpl_exp[k], "bpl");
        end

        load_pc(3'b101, 0, 0, 16'h0040); serve(1, 32'hF000_0000, 16'h0040, "jr_halt");
        repeat (50) @(negedge clk);
        check("halt_pc", pc, 16'h0040);
        check("halt_instr", instr, 32'hF000_0000);
        check("halt_req", imem_req, 0);
        check("halt_valid", instr_valid, 1);

        load_pc(3'b101, 0, 0, 16'hFFFF); serve(1, 32'hE000_0000, 16'hFFFF, "to_ffff");
        load_pc(3'b000, 0, 0, 16'd0);    serve(1, 32'h0000_0003, 16'h0000, "wrap");
        load_pc(3'b110, 1, 1, 16'd0);    serve(1, 32'h0000_0000, 16'h0001, "rsv110");

        load_pc(3'b000, 0, 0, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        @(negedge clk);
        imem_ack = 1'b0;
        check("rr_instr", instr, 32'hE000_0000);
        check("rr_valid", instr_valid, 0);
        check("rr_req", imem_req, 1);
        check("rr_addr", imem_addr, 16'h0000);
        serve(2, 32'h2100_0003, 16'h0000, "post_rst");
        check("pr_instr", instr, 32'h2100_0003);

`ifdef FETCH_TIMEOUT_EN
        load_pc(3'b000, 0, 0, 16'd0);
        repeat (7) @(negedge clk);
        check("to_pre_req", imem_req, 1);
        check("to_pre_err", fetch_err, 0);
        @(negedge clk);
        check("to_err", fetch_err, 1);
        check("to_req", imem_req, 0);
        check("to_valid", instr_valid, 0);
        repeat (5) @(negedge clk);
        loadPC = 1'b1; imem_ack = 1'b1;
        @(negedge clk);
        loadPC = 1'b0; imem_ack = 1'b0;
        check("to_sticky", fetch_err, 1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        serve(8, 32'h3300_0001, 16'h0000, "ack_at_limit");
        check("lim_err", fetch_err, 0);
        check("lim_instr", instr, 32'h3300_0001);
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
